// File: rtl/csa_accum_ctrl_if.sv
// Operand stream in, resolved-total stream out, plus busy/overflow status.
// master = operand source and result consumer; slave = csa_accum_ctrl.
interface csa_accum_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             busy;
  logic             ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, busy, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, busy, ovf
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: one 3:2 carry-save compression per accepted beat, then ripple-resolve of S/C.
// Latency: result valid 1..ACC_W+1 cycles after the last beat is accepted; one operand per cycle while accumulating.
// Backpressure: in_ready low from last beat until result handshake; result held while out_ready is low.
// Optional: define CSA_ACCUM_OVF_DETECT_EN to build the sticky overflow detector (otherwise ovf is tied low).
module csa_accum_ctrl #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_accum_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_s;
  logic [ACC_W-1:0] r_c;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_accept;
  logic [ACC_W-1:0] w_d;
  logic [ACC_W-1:0] w_maj;
  logic [ACC_W-1:0] w_and;
  logic [CNT_W-1:0] w_count_inc;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_d         = ACC_W'(bus.in_data);
  // Pre-shift carry terms; their MSB is what falls off on the shift.
  assign w_maj       = (r_s & r_c) | (r_s & w_d) | (r_c & w_d);
  assign w_and       = r_s & r_c;
  assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_count     <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s     <= w_d;
            r_c     <= '0;
            r_count <= CNT_W'(1);
            r_busy  <= 1'b1;
            if (bus.in_last) begin
              r_state    <= RESOLVE;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_s     <= r_s ^ r_c ^ w_d;
            r_c     <= w_maj << 1;
            r_count <= w_count_inc;
            if (bus.in_last) begin
              r_state    <= RESOLVE;
              r_in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          if (r_c == '0) begin
            r_out_sum   <= r_s;
            r_out_count <= r_count;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_s <= r_s ^ r_c;
            r_c <= w_and << 1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CSA_ACCUM_OVF_DETECT_EN
  logic r_ovf;

  // Any carry dropped off the top means the true total reached 2^ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_ovf <= 1'b0;
        ACCUM:   if (w_accept && w_maj[ACC_W-1]) r_ovf <= 1'b1;
        RESOLVE: if ((r_c != '0) && w_and[ACC_W-1]) r_ovf <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.busy      = r_busy;

endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
- Sequencing controller for the 3:2 carry-save adder datapath.
- Accepts a packet of WIDTH-bit unsigned operands over a valid/ready stream and accumulates them in redundant form (sum and carry registers), one 3:2 compression per accepted beat.
- On the last beat, iteratively resolves the redundant pair into a binary total and presents it on a valid/ready output.
- Sits between an operand source and any consumer of multi-operand sums.

Parameters:
- WIDTH, 4, operand width in bits.
- ACC_W, 8, accumulator, sum/carry register and result width; must satisfy ACC_W >= WIDTH.
- CNT_W, 8, operand-count register width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  controller accepts a beat this cycle.
- in_data  input  WIDTH  unsigned operand.
- in_last  input  1  final operand of the packet; qualified by in_valid.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_W  resolved packet total, modulo 2^ACC_W.
- out_count  output  CNT_W  operands in the packet, saturating.
- busy  output  1  high in any state other than IDLE.
- ovf  output  1  sticky overflow for the current packet; see Optional Feature.

Behaviour:
- Reset is asynchronous and active-low, on one clock domain. Reset state: IDLE.
  - Registers S, C, count and ovf reset to 0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_count=0, busy=0, ovf=0.
- Accept: a beat is accepted when in_valid && in_ready on a rising edge. Let D = zero-extended in_data.
- Compress: S' = S^C^D; C' = ((S&C)|(S&D)|(C&D)) << 1, truncated to ACC_W.
- IDLE: in_ready=1.
  - On accept: S=D, C=0, count=1, ovf cleared.
  - Go to RESOLVE if in_last, else ACCUM.
- ACCUM: in_ready=1.
  - On accept: compress and increment count, saturating at 2^CNT_W-1.
  - Go to RESOLVE if in_last.
  - No accept (bubble): hold all state.
- RESOLVE: in_ready=0. Each cycle, evaluate the current C:
  - If C==0: latch out_sum=S and out_count=count, then go to DONE.
  - Else: S'=S^C; C'=(S&C)<<1, truncated.
  - Terminates within ACC_W+1 cycles.
- DONE: in_ready=0; out_valid=1.
  - out_sum, out_count and ovf are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid drops next cycle.
- Latency: the last beat is accepted at edge T. Earliest out_valid is after edge T+1 (C==0 at first RESOLVE check). Worst case is after edge T+ACC_W+1.
- Throughput: one operand per cycle in ACCUM. A new packet can start in the cycle after the result handshake.
- Width rule: all arithmetic is unsigned modulo 2^ACC_W. Bits shifted out of the MSB of C are discarded.
- Reset asserted in any state aborts the packet immediately; the partial result is never emitted.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: CSA_ACCUM_OVF_DETECT_EN.
- Defined:
  - ovf is set when any compress or resolve step discards a 1 from bit ACC_W-1 of the pre-shift carry term.
  - This happens exactly when the true total is >= 2^ACC_W.
  - ovf is sticky until the next packet's first accept or reset, and is valid alongside out_valid.
- Undefined: ovf is tied to 0 and no detection logic is built.

Test Plan (WIDTH=4, ACC_W=8, CNT_W=8):
- Packet 5,7,3,15 on back-to-back beats, last on 15, out_ready=1 -> out_sum=30, out_count=4, ovf=0, out_valid exactly one cycle.
- Single beat 9 with in_last, out_ready=1 -> out_valid after edge T+1, out_sum=9, out_count=1; a new packet is accepted in the cycle after the handshake.
- 18 beats of 15, with the macro defined -> out_sum=14 (270 mod 256), out_count=18, ovf=1. Same stimulus without the macro -> ovf=0.
- Packet 1,2 with in_valid gaps of 3 cycles between beats, out_ready held low 5 cycles in DONE -> out_sum=3 stable throughout, in_ready=0 throughout DONE, handshake on the first out_ready=1.
- Packet 255-inducing sequence 15×17 = 255 -> out_sum=255, ovf=0; check the RESOLVE cycle count is <= 9.
- rst_n pulsed low mid-RESOLVE of packet 8,8,8 -> all outputs return immediately to reset values, no out_valid; the next packet 4 alone -> out_sum=4.
